// File: rtl/saber_centroid.sv
// saber_centroid: per-frame centroid of masked camera pixels.
//   Sums x/y coordinates and counts masked pixels each frame. On the frame
//   boundary strobe it snapshots the sums and count, then runs two parallel
//   restoring dividers (one quotient bit per cycle) to publish the centroid.
//   Frames with too few pixels take the same time but publish not-found.
//
// Optional feature: define SABER_CENTROID_SMOOTH_EN to pass found positions
//   through a first-order IIR filter, out <= (out + new) >> 1.
//
// Ports:
//   clk_in       system/pixel clock
//   rst_in       synchronous active-high reset
//   hcount_in    x coordinate of the current pixel
//   vcount_in    y coordinate of the current pixel
//   valid_in     current pixel is masked and accumulated
//   tabulate_in  single-cycle frame-boundary strobe
//   x_out        centroid x
//   y_out        centroid y
//   found_out    last published frame met MIN_PIXELS
//   valid_out    one-cycle strobe when x_out/y_out/found_out update
//   busy_out     divider (or equivalent wait) in progress
module saber_centroid #(
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned SUM_W      = 32,
    parameter int unsigned CNT_W      = 20
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    input  logic        tabulate_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        found_out,
    output logic        valid_out,
    output logic        busy_out
);

    localparam int unsigned X_W    = 11;
    localparam int unsigned Y_W    = 10;
    localparam int unsigned REM_W  = CNT_W + 1;
    localparam int unsigned STEP_W = $clog2(SUM_W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SUM_W-1:0]  sum_x, sum_y;
    logic [CNT_W-1:0]  count;

    logic [SUM_W-1:0]  dvd_x, dvd_y;
    logic [CNT_W-1:0]  dvsr;
    logic [CNT_W-1:0]  rem_x, rem_y;
    logic [X_W-1:0]    q_x;
    logic [Y_W-1:0]    q_y;
    logic [STEP_W-1:0] step;
    logic              found_pend;

    logic              snap_c;
    logic              last_c;
    logic [REM_W-1:0]  rx_sh_c, ry_sh_c;
    logic [REM_W-1:0]  rx_nxt_c, ry_nxt_c;
    logic              qx_bit_c, qy_bit_c;
    logic [X_W-1:0]    q_x_nxt_c;
    logic [Y_W-1:0]    q_y_nxt_c;

`ifdef SABER_CENTROID_SMOOTH_EN
    logic              filt_valid;
`endif

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        snap_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tabulate_in) begin
                    snap_c    = 1'b1;
                    state_nxt = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (step == STEP_W'(SUM_W - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = ST_PUBLISH;
                end
            end
            ST_PUBLISH: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // One restoring-division step for each axis; quotient keeps only the
    // output-width low bits since higher bits are truncated anyway.
    always_comb begin
        rx_sh_c   = {rem_x, dvd_x[SUM_W-1]};
        ry_sh_c   = {rem_y, dvd_y[SUM_W-1]};
        qx_bit_c  = (rx_sh_c >= {1'b0, dvsr});
        qy_bit_c  = (ry_sh_c >= {1'b0, dvsr});
        rx_nxt_c  = qx_bit_c ? (rx_sh_c - {1'b0, dvsr}) : rx_sh_c;
        ry_nxt_c  = qy_bit_c ? (ry_sh_c - {1'b0, dvsr}) : ry_sh_c;
        q_x_nxt_c = X_W'({q_x, qx_bit_c});
        q_y_nxt_c = Y_W'({q_y, qy_bit_c});
    end

    // Frame accumulators; a pixel coincident with the boundary starts the new frame
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (snap_c) begin
            sum_x <= valid_in ? SUM_W'(hcount_in) : '0;
            sum_y <= valid_in ? SUM_W'(vcount_in) : '0;
            count <= valid_in ? CNT_W'(1) : '0;
        end else if (valid_in) begin
            sum_x <= sum_x + SUM_W'(hcount_in);
            sum_y <= sum_y + SUM_W'(vcount_in);
            if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
        end
    end

    // Divider datapath and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dvd_x      <= '0;
            dvd_y      <= '0;
            dvsr       <= '0;
            rem_x      <= '0;
            rem_y      <= '0;
            q_x        <= '0;
            q_y        <= '0;
            step       <= '0;
            found_pend <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            found_out  <= 1'b0;
            valid_out  <= 1'b0;
            busy_out   <= 1'b0;
`ifdef SABER_CENTROID_SMOOTH_EN
            filt_valid <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            busy_out  <= (state_nxt != ST_IDLE);
            if (snap_c) begin
                dvd_x      <= sum_x;
                dvd_y      <= sum_y;
                dvsr       <= count;
                rem_x      <= '0;
                rem_y      <= '0;
                q_x        <= '0;
                q_y        <= '0;
                step       <= '0;
                found_pend <= (count >= CNT_W'(MIN_PIXELS));
            end else if (state == ST_DIVIDE) begin
                step <= step + STEP_W'(1);
                // Short frames only wait out the same number of cycles
                if (found_pend) begin
                    dvd_x <= dvd_x << 1;
                    dvd_y <= dvd_y << 1;
                    rem_x <= CNT_W'(rx_nxt_c);
                    rem_y <= CNT_W'(ry_nxt_c);
                    q_x   <= q_x_nxt_c;
                    q_y   <= q_y_nxt_c;
                end
                if (last_c) begin
                    valid_out <= 1'b1;
                    found_out <= found_pend;
                    if (found_pend) begin
`ifdef SABER_CENTROID_SMOOTH_EN
                        filt_valid <= 1'b1;
                        if (filt_valid) begin
                            x_out <= X_W'(((X_W+1)'(x_out) + (X_W+1)'(q_x_nxt_c)) >> 1);
                            y_out <= Y_W'(((Y_W+1)'(y_out) + (Y_W+1)'(q_y_nxt_c)) >> 1);
                        end else begin
                            x_out <= q_x_nxt_c;
                            y_out <= q_y_nxt_c;
                        end
`else
                        x_out <= q_x_nxt_c;
                        y_out <= q_y_nxt_c;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_saber_centroid.sv
// Testbench for saber_centroid: directed frame scenarios plus randomized
// frames, checked every cycle against a frame-level reference model.
module tb_saber_centroid;

    localparam int MIN_PIX = 16;
    localparam int LAT     = 33;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        valid_in = 1'b0;
    logic        tabulate_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        found_out;
    logic        valid_out;
    logic        busy_out;

    saber_centroid dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .valid_in    (valid_in),
        .tabulate_in (tabulate_in),
        .x_out       (x_out),
        .y_out       (y_out),
        .found_out   (found_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: running frame totals and the pending publish
    logic [31:0] m_sx, m_sy;
    int          m_cnt;
    bit          m_active;
    int          m_t0;
    int          m_px, m_py;
    bit          m_pf;
    int          m_x, m_y;
    bit          m_found;
    bit          m_filt;
    bit          m_valid, m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_cnt = 0;
        m_active = 0; m_t0 = 0;
        m_px = 0; m_py = 0; m_pf = 0;
        m_x = 0; m_y = 0; m_found = 0; m_filt = 0;
    endtask

    // Apply one cycle of inputs, advance the model and the DUT, check outputs
    task automatic step(input bit r, input bit v, input int h, input int vy, input bit t);
        bit idle_now;
        rst_in = r; valid_in = v; tabulate_in = t;
        hcount_in = 11'(h); vcount_in = 10'(vy);
        if (r) begin
            model_clear();
        end else begin
            idle_now = !(m_active && cyc >= m_t0 + 1 && cyc <= m_t0 + LAT);
            if (t && idle_now) begin
                m_active = 1;
                m_t0     = cyc;
                m_pf     = (m_cnt >= MIN_PIX);
                if (m_pf) begin
                    m_px = int'((m_sx / 32'(m_cnt)) % 2048);
                    m_py = int'((m_sy / 32'(m_cnt)) % 1024);
                end
                m_sx  = v ? 32'(h) : 0;
                m_sy  = v ? 32'(vy) : 0;
                m_cnt = v ? 1 : 0;
            end else if (v) begin
                m_sx = m_sx + 32'(h);
                m_sy = m_sy + 32'(vy);
                if (m_cnt != 20'hFFFFF) m_cnt++;
            end
        end
        @(posedge clk_in);
        #1;
        cyc++;
        m_valid = m_active && (cyc == m_t0 + LAT);
        m_busy  = m_active && (cyc >= m_t0 + 1) && (cyc <= m_t0 + LAT);
        if (m_valid) begin
            m_found = m_pf;
            if (m_pf) begin
`ifdef SABER_CENTROID_SMOOTH_EN
                if (m_filt) begin
                    m_x = (m_x + m_px) / 2;
                    m_y = (m_y + m_py) / 2;
                end else begin
                    m_x = m_px;
                    m_y = m_py;
                end
                m_filt = 1;
`else
                m_x = m_px;
                m_y = m_py;
`endif
            end
        end
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("busy_out",  32'(busy_out),  32'(m_busy));
        chk("x_out",     32'(x_out),     32'(m_x));
        chk("y_out",     32'(y_out),     32'(m_y));
        chk("found_out", 32'(found_out), 32'(m_found));
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, $urandom_range(0, 1279), $urandom_range(0, 719), 0);
    endtask

    task automatic rand_pix(input int n);
        repeat (n) begin
            step(0, 1, $urandom_range(0, 1279), $urandom_range(0, 719), 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    initial begin
        int pulses;
        model_clear();
        m_valid = 0; m_busy = 0;

        // Reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        idle(2);

        // 4x4 block at x=100..103, y=50..53
        for (int yy = 50; yy <= 53; yy++) begin
            for (int xx = 100; xx <= 103; xx++) begin
                step(0, 1, xx, yy, 0);
                if ($urandom_range(0, 1) == 1) idle(1);
            end
        end
        step(0, 0, 0, 0, 1);
        idle(LAT + 4);
        chk("blk_x", 32'(x_out), 32'd101);
        chk("blk_y", 32'(y_out), 32'd51);
        chk("blk_found", 32'(found_out), 32'd1);

        // 15 pixels: below threshold, position held
        rand_pix(15);
        step(0, 0, 0, 0, 1);
        idle(LAT + 4);
        chk("short_found", 32'(found_out), 32'd0);
        chk("short_x", 32'(x_out), 32'd101);
        chk("short_y", 32'(y_out), 32'd51);

        // Tabulate during DIVIDE is ignored; its pixels merge forward
        rand_pix(20);
        step(0, 0, 0, 0, 1);
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            step(0, 1, $urandom_range(0, 1279), $urandom_range(0, 719), 0);
            pulses += int'(valid_out);
        end
        step(0, 1, $urandom_range(0, 1279), $urandom_range(0, 719), 1);
        pulses += int'(valid_out);
        for (int i = 0; i < 30; i++) begin
            step(0, (i < 10), $urandom_range(0, 1279), $urandom_range(0, 719), 0);
            pulses += int'(valid_out);
        end
        chk("one_pulse", 32'(pulses), 32'd1);
        step(0, 0, 0, 0, 1);
        idle(LAT + 4);

        // Pixel coincident with tabulate starts the next frame
        step(0, 1, 640, 360, 1);
        repeat (15) step(0, 1, 640, 360, 0);
        idle(LAT);
        step(0, 0, 0, 0, 1);
        idle(LAT + 4);
`ifndef SABER_CENTROID_SMOOTH_EN
        chk("coinc_x", 32'(x_out), 32'd640);
        chk("coinc_y", 32'(y_out), 32'd360);
`endif
        chk("coinc_found", 32'(found_out), 32'd1);

        // Reset in the middle of DIVIDE aborts the publish
        rand_pix(20);
        step(0, 0, 0, 0, 1);
        idle(4);
        step(1, 0, 0, 0, 0);
        chk("abort_busy", 32'(busy_out), 32'd0);
        chk("abort_x", 32'(x_out), 32'd0);
        idle(LAT + 4);

        // Back-to-back at the maximum publish rate
        rand_pix(20);
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= LAT; i++)
            step(0, (i % 3 != 0), $urandom_range(0, 1279), $urandom_range(0, 719), 0);
        step(0, 0, 0, 0, 1);
        idle(LAT + 4);

        // Randomized frames, random spacing so some tabulates are ignored
        for (int f = 0; f < 10; f++) begin
            rand_pix($urandom_range(8, 40));
            step(0, $urandom_range(0, 1), $urandom_range(0, 1279), $urandom_range(0, 719), 1);
            for (int i = 0; i < int'($urandom_range(5, 45)); i++)
                step(0, $urandom_range(0, 1), $urandom_range(0, 1279), $urandom_range(0, 719), 0);
        end
        idle(LAT + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/saber_centroid.md
# saber_centroid

Computes the per-frame position of the saber tip from a stream of thresholded camera pixels and publishes it once per frame as a coordinate pair plus strobe. It sits between the camera mask/threshold stage and the trail renderer. It is the producer of the position/new-frame pair that the trail renderer consumes to update its history. It accumulates coordinate sums while pixels arrive, then divides them with an internal multi-cycle divider after the frame boundary.

## Interface
Parameters:
- `MIN_PIXELS`, default 16: minimum masked-pixel count for a frame to produce a valid position.
- `SUM_W`, default 32: width of the x/y coordinate-sum accumulators.
- `CNT_W`, default 20: width of the pixel-count accumulator.

Ports (one clock; reset is synchronous and active-high):
- `clk_in` input 1: system/pixel clock.
- `rst_in` input 1: synchronous active-high reset.
- `hcount_in` input 11: x coordinate of the current pixel.
- `vcount_in` input 10: y coordinate of the current pixel.
- `valid_in` input 1: current pixel is in the saber mask and is accumulated.
- `tabulate_in` input 1: single-cycle frame-boundary strobe.
- `x_out` output 11: centroid x.
- `y_out` output 10: centroid y.
- `found_out` output 1: last published frame met `MIN_PIXELS`.
- `valid_out` output 1: one-cycle strobe when `x_out`/`y_out`/`found_out` update; this drives the renderer's new-frame input.
- `busy_out` output 1: divider running.

## Operation
- Accumulators: `sum_x += hcount_in`, `sum_y += vcount_in`, `count += 1` on each cycle with `valid_in`=1.
  - `count` saturates at 2^CNT_W−1.
  - Sums wrap; no overflow occurs for 1280×720 at the default widths.
- FSM states: IDLE (accumulating, divider off), DIVIDE, PUBLISH.
- **IDLE, `tabulate_in`=1:**
  - Snapshot `sum_x`, `sum_y`, `count` into divider registers.
  - Clear the accumulators.
  - If `valid_in` is also 1 that cycle, the pixel is the first pixel of the new frame: the accumulators load that pixel instead of clearing to 0.
  - If the snapshot count is below `MIN_PIXELS`, skip DIVIDE: wait the same number of cycles, then PUBLISH with `found_out`=0 and `x_out`/`y_out` held.
  - Otherwise go to DIVIDE.
- **DIVIDE:**
  - Two parallel restoring dividers, quotient = floor(sum/count), one quotient bit per cycle, `SUM_W` cycles.
  - Quotients are truncated to 11 and 10 bits.
  - Accumulation of the next frame continues normally.
- **PUBLISH** (one cycle):
  - Register `x_out`/`y_out`, set `found_out`=1, pulse `valid_out`.
  - Return to IDLE.
- `tabulate_in` while not IDLE: ignored (no snapshot, no clear); that frame's pixels merge into the next frame.
- `busy_out`=1 in DIVIDE, in the equivalent skip wait, and in PUBLISH.

## Timing
- Reset values:
  - outputs: `x_out`=0, `y_out`=0, `found_out`=0, `valid_out`=0, `busy_out`=0;
  - internal: accumulators 0, FSM in IDLE.
- Reset mid-DIVIDE aborts; no `valid_out` follows.
- Latency: with `tabulate_in` high in cycle T, `valid_out` is high in cycle T+`SUM_W`+1 (T+33 at default), for exactly one cycle.
  - Identical for found and not-found frames.
- Outputs are registered and stable between `valid_out` pulses.
- Maximum publish rate: one per `SUM_W`+2 cycles.

## Configuration
- `SABER_CENTROID_SMOOTH_EN` defined: on a found frame, `x_out` <= (`x_out` + new_x) >> 1, and likewise for y (sum kept at 12/11 bits before the shift). This is a first-order IIR with α=½.
  - The first found frame after reset loads the raw value.
  - A not-found frame does not disturb the filter state.
- Not defined: a found frame publishes the raw quotient.

## Test plan
- 4×4 block x=100..103, y=50..53, then `tabulate_in` at T → `valid_out` at T+33, `x_out`=101, `y_out`=51, `found_out`=1.
- 15 pixels after a frame at (101,51), then tabulate → `valid_out` at T+33, `found_out`=0, `x_out`=101, `y_out`=51.
- Second `tabulate_in` at T+10 during DIVIDE → exactly one `valid_out`. Pixels sent between T and the next accepted tabulate appear in the following frame's centroid.
- `valid_in` and `tabulate_in` together with pixel (640,360), 15 more pixels at (640,360), tabulate → next publish gives (640,360), `found_out`=1.
- `rst_in` at T+5 during DIVIDE → no `valid_out`; all outputs 0; `busy_out`=0 the cycle after reset.
- With `SABER_CENTROID_SMOOTH_EN`: first found frame (101,51), next found frame raw (201,151) → outputs (101,51), then (151,101).
